digit_serial_adder: RTL and testbench

- Parametrised, multi-cycle add/subtract unit. Computes a ± b over WIDTH bits, DIGIT bits per clock, reusing one DIGIT-wide adder slice.
- Adds valid/ready handshakes, carry-in, subtract mode and status flags.
- Intended for datapaths where area matters more than latency, and as the building block for wider ALU experiments.

---
 rtl/digit_serial_adder_if.sv | 58 +++++
 rtl/digit_serial_adder.sv | 158 +++++++++++++++
 tb/tb_digit_serial_adder.sv | 263 ++++++++++++++++++++++++++
 3 files changed

// File: rtl/digit_serial_adder_if.sv
// -----------------------------------------------------------------------------
// digit_serial_adder_if
//   Groups the operand/result handshake of the digit-serial adder.
//
//   master modport (producer/consumer side, e.g. a testbench or datapath):
//     drives  in_valid, a, b, sub, carry_in, out_ready
//     samples in_ready, out_valid, sum, carry_out, overflow, zero
//   slave modport (the adder):
//     the mirror image of master.
//
//   WIDTH must match the WIDTH of the adder the interface is connected to.
// -----------------------------------------------------------------------------
interface digit_serial_adder_if #(
    parameter int WIDTH = 8
);
    logic             in_valid;
    logic             in_ready;
    logic [WIDTH-1:0] a;
    logic [WIDTH-1:0] b;
    logic             sub;
    logic             carry_in;
    logic             out_valid;
    logic             out_ready;
    logic [WIDTH-1:0] sum;
    logic             carry_out;
    logic             overflow;
    logic             zero;

    modport master (
        output in_valid,
        output a,
        output b,
        output sub,
        output carry_in,
        output out_ready,
        input  in_ready,
        input  out_valid,
        input  sum,
        input  carry_out,
        input  overflow,
        input  zero
    );

    modport slave (
        input  in_valid,
        input  a,
        input  b,
        input  sub,
        input  carry_in,
        input  out_ready,
        output in_ready,
        output out_valid,
        output sum,
        output carry_out,
        output overflow,
        output zero
    );
endinterface

// File: rtl/digit_serial_adder.sv
// -----------------------------------------------------------------------------
// digit_serial_adder
//   Multi-cycle add/subtract unit: computes a + b + carry_in or
//   a - b - carry_in over WIDTH bits, DIGIT bits per clock, reusing a single
//   DIGIT-wide adder slice. One operation takes N = WIDTH/DIGIT RUN cycles.
//
//   Ports:
//     clock  - sole clock, all state changes on its rising edge
//     reset  - synchronous, active-high; discards any operation in flight
//     bus    - digit_serial_adder_if.slave:
//                in_valid/in_ready   operand handshake (a, b, sub, carry_in)
//                out_valid/out_ready result handshake
//                sum                 result modulo 2^WIDTH
//                carry_out           carry out of MSB (subtract: 1 = no borrow)
//                overflow            two's-complement signed overflow
//                zero                sum == 0
//
//   Subtraction is done as a + ~b + ~carry_in, so the same slice serves both
//   modes and carry_out naturally reads as "no borrow" when subtracting.
// -----------------------------------------------------------------------------
module digit_serial_adder #(
    parameter int WIDTH = 8,
    parameter int DIGIT = 2
) (
    input  logic                clock,
    input  logic                reset,
    digit_serial_adder_if.slave bus
);
    localparam int N  = WIDTH / DIGIT;
    localparam int CW = (N > 1) ? $clog2(N) : 1;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        RUN  = 2'd1,
        DONE = 2'd2
    } state_t;

    // One DIGIT-wide slice. Returns {overflow, carry_out, sum}. The carry into
    // the slice MSB is recovered as sum_msb ^ x_msb ^ y_msb, which avoids an
    // empty part-select when DIGIT == 1.
    function automatic logic [DIGIT+1:0] add_digit(
        input logic [DIGIT-1:0] x,
        input logic [DIGIT-1:0] y,
        input logic             c
    );
        logic [DIGIT:0] full;
        logic           c_msb;
        full  = {1'b0, x} + {1'b0, y} + {{DIGIT{1'b0}}, c};
        c_msb = full[DIGIT-1] ^ x[DIGIT-1] ^ y[DIGIT-1];
        return {full[DIGIT] ^ c_msb, full[DIGIT], full[DIGIT-1:0]};
    endfunction

    state_t           state_r;
    logic [WIDTH-1:0] a_r;          // operand a, shifted right one digit per RUN cycle
    logic [WIDTH-1:0] b_r;          // operand b (inverted for subtract), shifted likewise
    logic [WIDTH-1:0] res_r;        // result assembled from the top down
    logic [WIDTH-1:0] sum_r;
    logic [CW-1:0]    cnt_r;
    logic             carry_r;
    logic             carry_out_r;
    logic             overflow_r;
    logic             zero_r;
    logic             in_ready_r;
    logic             out_valid_r;

    logic [DIGIT-1:0] slice_sum_s;
    logic             slice_cout_s;
    logic             slice_ovf_s;
    logic [WIDTH-1:0] res_next_s;
    logic             last_s;
    logic             accept_s;

    // Digit slice on the low digit of the operand shifters, plus the
    // result register's next value with the new digit entering at the top.
    always_comb begin
        {slice_ovf_s, slice_cout_s, slice_sum_s} =
            add_digit(a_r[DIGIT-1:0], b_r[DIGIT-1:0], carry_r);
        res_next_s = (res_r >> DIGIT) | (WIDTH'(slice_sum_s) << (WIDTH - DIGIT));
        last_s     = (cnt_r == CW'(N - 1));
        accept_s   = bus.in_valid & in_ready_r;
    end

    // Control FSM and datapath registers; handshake outputs are registered
    // copies of the state decode so no input reaches them combinationally.
    always_ff @(posedge clock) begin
        if (reset) begin
            state_r     <= IDLE;
            a_r         <= {WIDTH{1'b0}};
            b_r         <= {WIDTH{1'b0}};
            res_r       <= {WIDTH{1'b0}};
            sum_r       <= {WIDTH{1'b0}};
            cnt_r       <= {CW{1'b0}};
            carry_r     <= 1'b0;
            carry_out_r <= 1'b0;
            overflow_r  <= 1'b0;
            zero_r      <= 1'b0;
            in_ready_r  <= 1'b1;
            out_valid_r <= 1'b0;
        end else begin
            case (state_r)
                IDLE: begin
                    if (accept_s) begin
                        a_r        <= bus.a;
                        b_r        <= bus.b ^ {WIDTH{bus.sub}};
                        carry_r    <= bus.carry_in ^ bus.sub;
                        res_r      <= {WIDTH{1'b0}};
                        cnt_r      <= {CW{1'b0}};
                        state_r    <= RUN;
                        in_ready_r <= 1'b0;
                    end else begin
                        state_r    <= IDLE;
                    end
                end
                RUN: begin
                    a_r     <= a_r >> DIGIT;
                    b_r     <= b_r >> DIGIT;
                    carry_r <= slice_cout_s;
                    res_r   <= res_next_s;
                    cnt_r   <= cnt_r + CW'(1'b1);
                    if (last_s) begin
                        // Flags come from the MSB slice on its own edge.
                        sum_r       <= res_next_s;
                        carry_out_r <= slice_cout_s;
                        overflow_r  <= slice_ovf_s;
                        zero_r      <= (res_next_s == {WIDTH{1'b0}});
                        state_r     <= DONE;
                        out_valid_r <= 1'b1;
                    end else begin
                        state_r     <= RUN;
                    end
                end
                DONE: begin
                    // Result and flags stay put; only the handshake changes.
                    if (bus.out_ready) begin
                        state_r     <= IDLE;
                        out_valid_r <= 1'b0;
                        in_ready_r  <= 1'b1;
                    end else begin
                        state_r     <= DONE;
                    end
                end
                default: begin
                    state_r     <= IDLE;
                    in_ready_r  <= 1'b1;
                    out_valid_r <= 1'b0;
                end
            endcase
        end
    end

    assign bus.in_ready  = in_ready_r;
    assign bus.out_valid = out_valid_r;
    assign bus.sum       = sum_r;
    assign bus.carry_out = carry_out_r;
    assign bus.overflow  = overflow_r;
    assign bus.zero      = zero_r;

endmodule

// File: tb/tb_digit_serial_adder.sv
// -----------------------------------------------------------------------------
// tb_digit_serial_adder
//   Directed checks on an 8/2 instance (latency, flags, backpressure, ignored
//   input, mid-operation reset) followed by a random sweep run in lockstep on
//   8/8, 8/1 and 32/4 instances. Expected results come from a behavioural
//   WIDTH-bit model and are queued when an operation is driven.
// -----------------------------------------------------------------------------
module tb_digit_serial_adder;

    typedef struct packed {
        logic [31:0] sum;
        logic        co;
        logic        ov;
        logic        z;
    } exp_t;

    logic clock = 1'b0;
    logic reset;
    int   checks   = 0;
    int   failures = 0;

    exp_t q0[$];
    exp_t q1[$];
    exp_t q2[$];
    exp_t q3[$];

    always #5 clock = ~clock;

    digit_serial_adder_if #(.WIDTH(8))  if0 ();
    digit_serial_adder_if #(.WIDTH(8))  if1 ();
    digit_serial_adder_if #(.WIDTH(8))  if2 ();
    digit_serial_adder_if #(.WIDTH(32)) if3 ();

    digit_serial_adder #(.WIDTH(8),  .DIGIT(2)) dut0 (.clock(clock), .reset(reset), .bus(if0));
    digit_serial_adder #(.WIDTH(8),  .DIGIT(8)) dut1 (.clock(clock), .reset(reset), .bus(if1));
    digit_serial_adder #(.WIDTH(8),  .DIGIT(1)) dut2 (.clock(clock), .reset(reset), .bus(if2));
    digit_serial_adder #(.WIDTH(32), .DIGIT(4)) dut3 (.clock(clock), .reset(reset), .bus(if3));

    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s observed=0x%0h expected=0x%0h", tag, obs, exp);
        end
    endtask

    // Behavioural reference: exact integer arithmetic, overflow from the
    // signed range of the true result.
    function automatic exp_t model(input int w, input logic [31:0] a, input logic [31:0] b,
                                   input logic sub, input logic cin);
        longint m, ua, ub, sa, sb, ci, full, st, hi, lo;
        exp_t   e;
        m  = (64'sd1 <<< w) - 64'sd1;
        ua = longint'({32'd0, a}) & m;
        ub = longint'({32'd0, b}) & m;
        sa = (ua >= (64'sd1 <<< (w - 1))) ? ua - (m + 64'sd1) : ua;
        sb = (ub >= (64'sd1 <<< (w - 1))) ? ub - (m + 64'sd1) : ub;
        ci = cin ? 64'sd1 : 64'sd0;
        if (!sub) begin
            full = ua + ub + ci;
            st   = sa + sb + ci;
            e.co = ((full >>> w) & 64'sd1) != 64'sd0;
        end else begin
            full = ua - ub - ci;
            st   = sa - sb - ci;
            e.co = (ua >= ub + ci);
        end
        hi    = (64'sd1 <<< (w - 1)) - 64'sd1;
        lo    = -(64'sd1 <<< (w - 1));
        e.ov  = (st > hi) || (st < lo);
        e.sum = 32'(full & m);
        e.z   = ((full & m) == 64'sd0);
        return e;
    endfunction

    task automatic step();
        @(posedge clock);
        #1;
    endtask

    // Wait for in_ready, present one operation for exactly one edge.
    task automatic issue0(input logic [7:0] a, input logic [7:0] b, input logic sub, input logic cin);
        int n = 0;
        while (if0.in_ready !== 1'b1 && n < 50) begin
            step();
            n++;
        end
        check("issue0_ready", 64'(if0.in_ready), 64'd1);
        if0.a        = a;
        if0.b        = b;
        if0.sub      = sub;
        if0.carry_in = cin;
        if0.in_valid = 1'b1;
        q0.push_back(model(8, {24'd0, a}, {24'd0, b}, sub, cin));
        step();
        if0.in_valid = 1'b0;
    endtask

    // Wait for a result, compare it to the scoreboard head, consume it.
    task automatic collect0(input string tag);
        int   n = 0;
        exp_t e;
        while (if0.out_valid !== 1'b1 && n < 50) begin
            step();
            n++;
        end
        check({tag, "_valid"}, 64'(if0.out_valid), 64'd1);
        check({tag, "_sbq"}, 64'(q0.size() > 0), 64'd1);
        e = (q0.size() > 0) ? q0.pop_front() : '0;
        check({tag, "_sum"}, 64'(if0.sum), 64'(e.sum[7:0]));
        check({tag, "_cout"}, 64'(if0.carry_out), 64'(e.co));
        check({tag, "_ovf"}, 64'(if0.overflow), 64'(e.ov));
        check({tag, "_zero"}, 64'(if0.zero), 64'(e.z));
        step();
    endtask

    logic [7:0]  ta [6] = '{8'd255, 8'd127, 8'd7,  8'd5, 8'd128, 8'd9};
    logic [7:0]  tb [6] = '{8'd1,   8'd1,   8'd12, 8'd7, 8'd1,   8'd9};
    logic        ts [6] = '{1'b0,   1'b0,   1'b0,  1'b1, 1'b1,   1'b1};
    logic        tc [6] = '{1'b0,   1'b0,   1'b1,  1'b0, 1'b0,   1'b0};
    logic [31:0] ra, rb;
    logic        rs, rc;
    logic [2:0]  got;
    exp_t        eh;
    int          n;

    initial begin
        if0.in_valid = 1'b0; if0.a = 8'd0; if0.b = 8'd0; if0.sub = 1'b0; if0.carry_in = 1'b0; if0.out_ready = 1'b1;
        if1.in_valid = 1'b0; if1.a = 8'd0; if1.b = 8'd0; if1.sub = 1'b0; if1.carry_in = 1'b0; if1.out_ready = 1'b1;
        if2.in_valid = 1'b0; if2.a = 8'd0; if2.b = 8'd0; if2.sub = 1'b0; if2.carry_in = 1'b0; if2.out_ready = 1'b1;
        if3.in_valid = 1'b0; if3.a = 32'd0; if3.b = 32'd0; if3.sub = 1'b0; if3.carry_in = 1'b0; if3.out_ready = 1'b1;

        // Reset state
        reset = 1'b1;
        step(); step(); step();
        reset = 1'b0;
        check("rst_in_ready", 64'(if0.in_ready), 64'd1);
        check("rst_out_valid", 64'(if0.out_valid), 64'd0);
        check("rst_sum", 64'(if0.sum), 64'd0);
        check("rst_flags", 64'({if0.carry_out, if0.overflow, if0.zero}), 64'd0);

        // Latency: 3 + 2, valid exactly 4 edges after acceptance
        issue0(8'd3, 8'd2, 1'b0, 1'b0);
        for (int i = 1; i <= 4; i++) begin
            step();
            check($sformatf("lat_valid_%0d", i), 64'(if0.out_valid), (i == 4) ? 64'd1 : 64'd0);
            check($sformatf("lat_in_ready_%0d", i), 64'(if0.in_ready), 64'd0);
        end
        collect0("add_3_2");
        check("lat_in_ready_back", 64'(if0.in_ready), 64'd1);
        check("lat_valid_drop", 64'(if0.out_valid), 64'd0);

        // Directed flag cases
        for (int i = 0; i < 6; i++) begin
            issue0(ta[i], tb[i], ts[i], tc[i]);
            collect0($sformatf("dir_%0d", i));
        end

        // Backpressure with new operands held on in_valid throughout
        if0.out_ready = 1'b0;
        issue0(8'd100, 8'd50, 1'b0, 1'b0);
        if0.in_valid = 1'b1;
        if0.a        = 8'd1;
        if0.b        = 8'd1;
        n = 0;
        while (if0.out_valid !== 1'b1 && n < 50) begin
            step();
            n++;
        end
        check("bp_valid", 64'(if0.out_valid), 64'd1);
        eh = (q0.size() > 0) ? q0.pop_front() : '0;
        for (int i = 0; i < 10; i++) begin
            check("bp_result", 64'({if0.sum, if0.carry_out, if0.overflow, if0.zero}),
                  64'({eh.sum[7:0], eh.co, eh.ov, eh.z}));
            check("bp_in_ready", 64'(if0.in_ready), 64'd0);
            check("bp_hold_valid", 64'(if0.out_valid), 64'd1);
            step();
        end
        if0.in_valid  = 1'b0;
        if0.out_ready = 1'b1;
        step();
        check("bp_release_valid", 64'(if0.out_valid), 64'd0);
        for (int i = 0; i < 6; i++) begin
            step();
            check("bp_no_extra", 64'({if0.out_valid, if0.in_ready}), 64'b01);
        end
        check("bp_sb_empty", 64'(q0.size()), 64'd0);

        // Reset after two digits of RUN: nothing of the operation survives
        issue0(8'd7, 8'd12, 1'b0, 1'b1);
        step(); step();
        reset = 1'b1;
        step();
        reset = 1'b0;
        q0.delete();
        check("mid_rst_in_ready", 64'(if0.in_ready), 64'd1);
        check("mid_rst_out_valid", 64'(if0.out_valid), 64'd0);
        check("mid_rst_sum", 64'(if0.sum), 64'd0);
        check("mid_rst_flags", 64'({if0.carry_out, if0.overflow, if0.zero}), 64'd0);
        for (int i = 0; i < 5; i++) begin
            step();
            check("mid_rst_quiet", 64'(if0.out_valid), 64'd0);
        end
        issue0(8'd7, 8'd12, 1'b0, 1'b0);
        collect0("after_rst");

        // Random sweep: 8/8 (N=1), 8/1 (N=8), 32/4 (N=8) in lockstep
        for (int v = 0; v < 1000; v++) begin
            n = 0;
            while ((if1.in_ready !== 1'b1 || if2.in_ready !== 1'b1 || if3.in_ready !== 1'b1) && n < 50) begin
                step();
                n++;
            end
            check("sw_ready", 64'({if1.in_ready, if2.in_ready, if3.in_ready}), 64'b111);
            ra = $urandom;
            rb = $urandom;
            rs = 1'($urandom);
            rc = 1'($urandom);
            if (v % 8 == 0) ra = 32'hFFFF_FFFF;
            if (v % 8 == 4) rb = 32'h8000_0080;
            if1.a = ra[7:0];   if1.b = rb[7:0];   if1.sub = rs; if1.carry_in = rc; if1.in_valid = 1'b1;
            if2.a = rb[7:0];   if2.b = ra[7:0];   if2.sub = rs; if2.carry_in = rc; if2.in_valid = 1'b1;
            if3.a = ra;        if3.b = rb;        if3.sub = rs; if3.carry_in = rc; if3.in_valid = 1'b1;
            q1.push_back(model(8,  ra, rb, rs, rc));
            q2.push_back(model(8,  rb, ra, rs, rc));
            q3.push_back(model(32, ra, rb, rs, rc));
            step();
            if1.in_valid = 1'b0;
            if2.in_valid = 1'b0;
            if3.in_valid = 1'b0;
            got = 3'b000;
            for (int c = 1; c <= 20 && got != 3'b111; c++) begin
                step();
                if (if1.out_valid === 1'b1 && !got[0]) begin
                    got[0] = 1'b1;
                    check("sw8x8_lat", 64'(c), 64'd1);
                    eh = (q1.size() > 0) ? q1.pop_front() : '0;
                    check("sw8x8_res", 64'({if1.sum, if1.carry_out, if1.overflow, if1.zero}),
                          64'({eh.sum[7:0], eh.co, eh.ov, eh.z}));
                end
                if (if2.out_valid === 1'b1 && !got[1]) begin
                    got[1] = 1'b1;
                    check("sw8x1_lat", 64'(c), 64'd8);
                    eh = (q2.size() > 0) ? q2.pop_front() : '0;
                    check("sw8x1_res", 64'({if2.sum, if2.carry_out, if2.overflow, if2.zero}),
                          64'({eh.sum[7:0], eh.co, eh.ov, eh.z}));
                end
                if (if3.out_valid === 1'b1 && !got[2]) begin
                    got[2] = 1'b1;
                    check("sw32x4_lat", 64'(c), 64'd8);
                    eh = (q3.size() > 0) ? q3.pop_front() : '0;
                    check("sw32x4_res", 64'({if3.sum, if3.carry_out, if3.overflow, if3.zero}),
                          64'({eh.sum, eh.co, eh.ov, eh.z}));
                end
            end
            check("sw_all_delivered", 64'(got), 64'b111);
        end

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
